// File: rtl/mod7177_pkg.sv
// Shared constants for the mod-7177 reduction datapath.
//   Q         : modulus
//   QHALF     : largest magnitude of a centred residue
//   IN_W      : width of a signed operand entering the reducer
//   OUT_W     : width of the signed centred residue
//   RED_LAT   : register stages inside the reducer
//   SHARE_LAT : operand-accept to result latency of the shared wrapper
package mod7177_pkg;
    localparam int Q         = 7177;
    localparam int QHALF     = 3588;
    localparam int IN_W      = 35;
    localparam int OUT_W     = 13;
    localparam int RED_LAT   = 3;
    localparam int SHARE_LAT = RED_LAT + 1;
endpackage

// File: rtl/mod7177S35.sv
// Reducer: signed 35-bit operand -> centred signed residue mod 7177 in
// [-QHALF, QHALF]. Three register stages, accepts a new operand every cycle,
// never stalls.
// Ports:
//   clk   : rising-edge clock
//   Reset : synchronous active-high, clears the stage registers
//   In    : signed operand
//   Out   : centred residue of the operand presented RED_LAT cycles earlier
module mod7177S35
    import mod7177_pkg::*;
(
    input  logic                    clk,
    input  logic                    Reset,
    input  logic signed [IN_W-1:0]  In,
    output logic signed [OUT_W-1:0] Out
);

    localparam logic signed [IN_W-1:0] Q_S = IN_W'(Q);

    // Residue in [0, Q). The remainder takes the dividend's sign, so a
    // negative remainder is lifted by one modulus.
    function automatic logic [OUT_W-1:0] mod_pos(input logic signed [IN_W-1:0] x);
        logic signed [IN_W-1:0] r;
        r = x % Q_S;
        if (r < 0) begin
            r = r + Q_S;
        end
        return OUT_W'(r);
    endfunction

    // Map [0, Q) onto [-QHALF, QHALF]; the subtraction wraps correctly in
    // OUT_W-bit two's complement.
    function automatic logic signed [OUT_W-1:0] centre(input logic [OUT_W-1:0] r);
        if (r > OUT_W'(QHALF)) begin
            return $signed(r - OUT_W'(Q));
        end
        return $signed(r);
    endfunction

    logic signed [IN_W-1:0]  x_p0;
    logic        [OUT_W-1:0] r_p1;
    logic signed [OUT_W-1:0] y_p2;

    always_ff @(posedge clk) begin
        if (Reset) begin
            x_p0 <= '0;
            r_p1 <= '0;
            y_p2 <= '0;
        end else begin
            // p0: capture operand
            x_p0 <= In;
            // p1: non-negative residue
            r_p1 <= mod_pos(x_p0);
            // p2: centred residue
            y_p2 <= centre(r_p1);
        end
    end

    assign Out = y_p2;

endmodule

// File: rtl/mod7177_rr_share.sv
// Round-robin front end that shares one mod7177S35 reducer among NREQ
// requesters and tags every result with the index of its requester.
// Ports:
//   clk       : rising-edge clock
//   Reset     : synchronous active-high; also resets the reducer
//   req_valid : per-requester operand present
//   req_data  : packed signed operands, slice i = [IN_W*i +: IN_W]
//   req_ready : one-hot grant (zero when idle or in reset)
//   out_valid : out_id/out_data carry a result this cycle
//   out_id    : requester index of the result
//   out_data  : centred residue in [-QHALF, QHALF]
//   busy      : any operand still in flight
module mod7177_rr_share
    import mod7177_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic                    clk,
    input  logic                    Reset,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*IN_W-1:0]    req_data,
    output logic [NREQ-1:0]         req_ready,
    output logic                    out_valid,
    output logic [IDW-1:0]          out_id,
    output logic signed [OUT_W-1:0] out_data,
    output logic                    busy
);

    // Returns {found, index}: first valid requester at or after ptr,
    // wrapping. Scanning offsets downward lets the smallest offset win.
    function automatic logic [IDW:0] rr_pick(input logic [NREQ-1:0] vld,
                                             input logic [IDW-1:0]  ptr);
        logic [IDW:0] res;
        int           idx;
        res = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            idx = (int'(ptr) + i) % NREQ;
            if (vld[IDW'(idx)]) begin
                res = {1'b1, IDW'(idx)};
            end
        end
        return res;
    endfunction

    logic [IDW-1:0]          ptr_q, ptr_d;
    logic                    grant_found;
    logic [IDW-1:0]          grant_idx;
    logic                    accept;
    logic signed [IN_W-1:0]  in_reg_q, in_reg_d;
    logic [SHARE_LAT-1:0]    tag_vld_q;
    logic [IDW-1:0]          tag_id_q [SHARE_LAT];
    logic signed [OUT_W-1:0] red_out;

    always_comb begin
        {grant_found, grant_idx} = rr_pick(req_valid, ptr_q);
        // Nothing may be accepted while reset is held.
        accept    = grant_found && !Reset;
        req_ready = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_ready[i] = accept && (grant_idx == IDW'(i));
        end
        ptr_d    = ptr_q;
        in_reg_d = '0;
        if (accept) begin
            ptr_d    = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + IDW'(1);
            in_reg_d = $signed(req_data[grant_idx*IN_W +: IN_W]);
        end
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            ptr_q     <= '0;
            in_reg_q  <= '0;
            tag_vld_q <= '0;
            for (int i = 0; i < SHARE_LAT; i++) begin
                tag_id_q[i] <= '0;
            end
        end else begin
            ptr_q     <= ptr_d;
            // Stage 0: operand register; the tag stage moves with it and a
            // zero valid bit marks a bubble.
            in_reg_q  <= in_reg_d;
            tag_vld_q <= {tag_vld_q[SHARE_LAT-2:0], accept};
            tag_id_q[0] <= accept ? grant_idx : '0;
            // Stages 1..3: tags follow the reducer's internal stages.
            for (int i = 1; i < SHARE_LAT; i++) begin
                tag_id_q[i] <= tag_id_q[i-1];
            end
        end
    end

    mod7177S35 u_red (
        .clk   (clk),
        .Reset (Reset),
        .In    (in_reg_q),
        .Out   (red_out)
    );

    assign out_valid = tag_vld_q[SHARE_LAT-1];
    assign out_id    = tag_id_q[SHARE_LAT-1];
    assign out_data  = red_out;
    assign busy      = |tag_vld_q;

endmodule
